// File: rtl/video_timing_pkg.sv
// Shared definitions for the RGB panel raster timing generator.
// Holds the default 800x480 panel timing, a compact timing set for short
// simulations, the flag bundle carried through the output delay line, and a
// width helper that never returns zero.
package video_timing_pkg;

  // Default 800x480 panel timing.
  localparam int DefHorActive     = 800;
  localparam int DefHorBackPorch  = 26;
  localparam int DefHorFrontPorch = 210;
  localparam int DefHorSync       = 20;
  localparam int DefVerActive     = 480;
  localparam int DefVerBackPorch  = 13;
  localparam int DefVerFrontPorch = 22;
  localparam int DefVerSync       = 10;

  // Compact timing: 8 cycles per line, 6 lines per frame.
  localparam int TestHorActive     = 4;
  localparam int TestHorBackPorch  = 2;
  localparam int TestHorFrontPorch = 1;
  localparam int TestHorSync       = 1;
  localparam int TestVerActive     = 3;
  localparam int TestVerBackPorch  = 1;
  localparam int TestVerFrontPorch = 1;
  localparam int TestVerSync       = 1;

  // Per-cycle timing flags; hs/vs already carry the configured polarity.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic line_start;
    logic frame_start;
  } timing_flags_t;

  // $clog2 that yields at least 1, so a single-value range still gets a bit.
  function automatic int vt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vt_delay_line.sv
// Fixed-latency register pipeline.
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low reset; every stage loads RESET_VALUE
//   d     - data in
//   q     - data out, DEPTH clocks after d (combinational when DEPTH = 0)
// Stages load every clock; there is no enable, so latency is a fixed count of
// clock cycles.
module vt_delay_line #(
  parameter int               WIDTH       = 1,
  parameter int               DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    assign q = d;

    logic unused_bypass;
    assign unused_bypass = clk ^ rst_n;
  end else begin : g_stages
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= RESET_VALUE;
        end
      end else begin
        stage_q[0] <= d;
        for (int i = 1; i < DEPTH; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator for the RGB panel path.
// Ports:
//   clk_rgb     - pixel clock
//   rst_n       - synchronous active-low reset
//   en          - advance the raster counters this cycle
//   x, y        - active column/row, 0 outside the active window
//   hs, vs      - syncs, polarity set by HS_ACTIVE_HIGH / VS_ACTIVE_HIGH
//   de          - data enable, high only inside the active window
//   line_start  - one-cycle strobe at h_cnt == 0 (qualified by en)
//   frame_start - one-cycle strobe at h_cnt == 0 && v_cnt == 0 (qualified by en)
//   frame_cnt   - completed-frame count, wraps; not delayed by PIPE_DELAY
// Each line is back porch, active, front porch, sync; frames likewise in lines.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int HOR_ACTIVE_PIXELS      = DefHorActive,
  parameter int HOR_BACK_PORCH_PIXELS  = DefHorBackPorch,
  parameter int HOR_FRONT_PORCH_PIXELS = DefHorFrontPorch,
  parameter int HOR_SYNC_PIXELS        = DefHorSync,
  parameter int VER_ACTIVE_PIXELS      = DefVerActive,
  parameter int VER_BACK_PORCH_PIXELS  = DefVerBackPorch,
  parameter int VER_FRONT_PORCH_PIXELS = DefVerFrontPorch,
  parameter int VER_SYNC_PIXELS        = DefVerSync,
  parameter bit HS_ACTIVE_HIGH         = 1'b1,
  parameter bit VS_ACTIVE_HIGH         = 1'b1,
  parameter int PIPE_DELAY             = 0,
  parameter int FRAME_CNT_WIDTH        = 16,
  localparam int X_WIDTH               = vt_width(HOR_ACTIVE_PIXELS),
  localparam int Y_WIDTH               = vt_width(VER_ACTIVE_PIXELS)
) (
  input  logic                       clk_rgb,
  input  logic                       rst_n,
  input  logic                       en,
  output logic [X_WIDTH-1:0]         x,
  output logic [Y_WIDTH-1:0]         y,
  output logic                       hs,
  output logic                       vs,
  output logic                       de,
  output logic                       line_start,
  output logic                       frame_start,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt
);

  localparam int HOR_TOTAL = HOR_ACTIVE_PIXELS + HOR_BACK_PORCH_PIXELS +
                             HOR_FRONT_PORCH_PIXELS + HOR_SYNC_PIXELS;
  localparam int VER_TOTAL = VER_ACTIVE_PIXELS + VER_BACK_PORCH_PIXELS +
                             VER_FRONT_PORCH_PIXELS + VER_SYNC_PIXELS;
  localparam int HW = vt_width(HOR_TOTAL);
  localparam int VW = vt_width(VER_TOTAL);

  // Region boundaries in counter width.
  localparam logic [HW-1:0] H_ACT_START  = HW'(HOR_BACK_PORCH_PIXELS);
  localparam logic [HW-1:0] H_ACT_END    = HW'(HOR_BACK_PORCH_PIXELS + HOR_ACTIVE_PIXELS);
  localparam logic [HW-1:0] H_SYNC_START = HW'(HOR_BACK_PORCH_PIXELS + HOR_ACTIVE_PIXELS +
                                               HOR_FRONT_PORCH_PIXELS);
  localparam logic [HW-1:0] H_MAX        = HW'(HOR_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_START  = VW'(VER_BACK_PORCH_PIXELS);
  localparam logic [VW-1:0] V_ACT_END    = VW'(VER_BACK_PORCH_PIXELS + VER_ACTIVE_PIXELS);
  localparam logic [VW-1:0] V_SYNC_START = VW'(VER_BACK_PORCH_PIXELS + VER_ACTIVE_PIXELS +
                                               VER_FRONT_PORCH_PIXELS);
  localparam logic [VW-1:0] V_MAX        = VW'(VER_TOTAL - 1);

  localparam int FLAGS_WIDTH = $bits(timing_flags_t);
  localparam int PIPE_WIDTH  = FLAGS_WIDTH + X_WIDTH + Y_WIDTH;
  // Inactive values loaded into the delay line on reset.
  localparam logic [PIPE_WIDTH-1:0] PIPE_IDLE = {~HS_ACTIVE_HIGH, ~VS_ACTIVE_HIGH, 3'b000,
                                                 {X_WIDTH{1'b0}}, {Y_WIDTH{1'b0}}};

  // Elaboration-time parameter checks.
  if (HOR_ACTIVE_PIXELS < 1 || VER_ACTIVE_PIXELS < 1) begin : g_chk_active
    $error("video_timing_gen: active size must be at least 1");
  end
  if (HOR_BACK_PORCH_PIXELS < 1 || HOR_FRONT_PORCH_PIXELS < 1 ||
      HOR_SYNC_PIXELS < 1) begin : g_chk_hor
    $error("video_timing_gen: horizontal porch/sync widths must be at least 1");
  end
  if (VER_BACK_PORCH_PIXELS < 1 || VER_FRONT_PORCH_PIXELS < 1 ||
      VER_SYNC_PIXELS < 1) begin : g_chk_ver
    $error("video_timing_gen: vertical porch/sync widths must be at least 1");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 8) begin : g_chk_pipe
    $error("video_timing_gen: PIPE_DELAY must be in 0..8");
  end
  if (FRAME_CNT_WIDTH < 1) begin : g_chk_fcnt
    $error("video_timing_gen: FRAME_CNT_WIDTH must be at least 1");
  end

  // Raster counters and frame counter.
  logic [HW-1:0]              h_cnt_q, h_cnt_d;
  logic [VW-1:0]              v_cnt_q, v_cnt_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic                       h_wrap, v_wrap;

  assign h_wrap = (h_cnt_q == H_MAX);
  assign v_wrap = (v_cnt_q == V_MAX);

  always_comb begin
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (en) begin
      if (h_wrap) begin
        h_cnt_d = '0;
        if (v_wrap) begin
          v_cnt_d     = '0;
          frame_cnt_d = frame_cnt_q + 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + 1'b1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_rgb) begin
    if (!rst_n) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      frame_cnt_q <= '0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Raw region decode straight from the counters.
  timing_flags_t      flags_raw;
  logic [X_WIDTH-1:0] x_raw;
  logic [Y_WIDTH-1:0] y_raw;
  logic [HW-1:0]      h_off;
  logic [VW-1:0]      v_off;
  logic               h_in, v_in;

  always_comb begin
    h_in  = (h_cnt_q >= H_ACT_START) && (h_cnt_q < H_ACT_END);
    v_in  = (v_cnt_q >= V_ACT_START) && (v_cnt_q < V_ACT_END);
    h_off = h_cnt_q - H_ACT_START;
    v_off = v_cnt_q - V_ACT_START;

    flags_raw.de          = h_in && v_in;
    flags_raw.hs          = (h_cnt_q >= H_SYNC_START) ~^ HS_ACTIVE_HIGH;
    flags_raw.vs          = (v_cnt_q >= V_SYNC_START) ~^ VS_ACTIVE_HIGH;
    // Strobes only fire on cycles that actually advance the raster.
    flags_raw.line_start  = en && (h_cnt_q == '0);
    flags_raw.frame_start = en && (h_cnt_q == '0) && (v_cnt_q == '0);

    x_raw = flags_raw.de ? X_WIDTH'(h_off) : '0;
    y_raw = flags_raw.de ? Y_WIDTH'(v_off) : '0;
  end

  // Equal delay on every raster output keeps sync/de aligned with the renderer.
  logic [PIPE_WIDTH-1:0] pipe_out;
  timing_flags_t         flags_out;

  vt_delay_line #(
    .WIDTH       (PIPE_WIDTH),
    .DEPTH       (PIPE_DELAY),
    .RESET_VALUE (PIPE_IDLE)
  ) u_delay (
    .clk   (clk_rgb),
    .rst_n (rst_n),
    .d     ({flags_raw, x_raw, y_raw}),
    .q     (pipe_out)
  );

  assign flags_out   = pipe_out[PIPE_WIDTH-1 -: FLAGS_WIDTH];
  assign x           = pipe_out[X_WIDTH+Y_WIDTH-1 -: X_WIDTH];
  assign y           = pipe_out[Y_WIDTH-1:0];
  assign hs          = flags_out.hs;
  assign vs          = flags_out.vs;
  assign de          = flags_out.de;
  assign line_start  = flags_out.line_start;
  assign frame_start = flags_out.frame_start;
  assign frame_cnt   = frame_cnt_q;

endmodule
